// File: rtl/ingress_pkg.sv
// ingress_pkg: shared state encoding and default constants for the symbol ingress front end
package ingress_pkg;
    typedef enum logic [1:0] {IDLE, QUAL, HELD, RELEASE} state_t;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_FIFO_DEPTH = 4;
    localparam logic [7:0] DROP_SAT = 8'd255;
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: first-word-fall-through buffer whose head holds the last popped value when empty
module sync_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clr,
    input  logic                        push,
    input  logic                        pop,
    input  logic [DATA_W-1:0]           din,
    output logic [DATA_W-1:0]           dout,
    output logic                        valid,
    output logic                        full,
    output logic [$clog2(DEPTH):0]      level
);
    localparam int AW = $clog2(DEPTH);
    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [DATA_W-1:0] hold;
    logic do_push, do_pop;
    assign valid = level != '0;
    assign full = level == (AW+1)'(DEPTH);
    assign do_pop = pop && valid;
    assign do_push = push && (!full || do_pop);
    assign dout = valid ? mem[rd_ptr] : hold;
    // storage write; contents need no reset since level gates visibility
    always_ff @(posedge clk)
        if (do_push) mem[wr_ptr] <= din;
    // pointers, occupancy and the value shown while empty
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level <= '0;
            hold <= '0;
        end else begin
            wr_ptr <= do_push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= do_pop ? rd_ptr + 1'b1 : rd_ptr;
            hold <= do_pop ? mem[rd_ptr] : hold;
            level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
endmodule

// File: rtl/symbol_ingress_sampler.sv
// symbol_ingress_sampler: synchronizes and debounces pad strobes, buffering one symbol per pulse
module symbol_ingress_sampler
    import ingress_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic                            wb_clk_i,
    input  logic                            wb_rst_i,
    input  logic [DATA_W-1:0]               pad_data_i,
    input  logic                            pad_strobe_i,
    input  logic                            clr_i,
    output logic                            sym_valid_o,
    output logic [DATA_W-1:0]               sym_data_o,
    input  logic                            sym_ready_i,
    output logic                            overflow_o,
    output logic [7:0]                      drop_count_o,
    output logic [$clog2(FIFO_DEPTH):0]     fifo_level_o
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB = CW'(DEBOUNCE_CYCLES);
    logic [SYNC_STAGES-1:0] st_sync;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] d_sync;
    logic strobe_s;
    logic [DATA_W-1:0] data_s, cand;
    state_t state;
    logic [CW-1:0] cnt, cnt_inc;
    logic push, pop, full;
    assign strobe_s = st_sync[SYNC_STAGES-1];
    assign data_s = d_sync[SYNC_STAGES-1];
    assign cnt_inc = cnt + 1'b1;
    assign pop = sym_valid_o && sym_ready_i;
    assign push = !clr_i && strobe_s && ((state == IDLE && DEBOUNCE_CYCLES == 1) ||
                  (state == QUAL && data_s == cand && cnt_inc == DB));
    // pad synchronizers; only a full reset flushes them
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            st_sync <= '0;
            d_sync <= '0;
        end else begin
            st_sync <= {st_sync[SYNC_STAGES-2:0], pad_strobe_i};
            d_sync <= {d_sync[SYNC_STAGES-2:0], pad_data_i};
        end
    end
    // debounce FSM: qualify a stable high strobe, then wait for a stable low before rearming
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_i) begin
            state <= IDLE;
            cnt <= '0;
            cand <= '0;
        end else begin
            unique case (state)
                IDLE: if (strobe_s) begin
                    state <= (DEBOUNCE_CYCLES == 1) ? HELD : QUAL;
                    cnt <= CW'(1);
                    cand <= data_s;
                end
                QUAL: if (!strobe_s) state <= IDLE;
                else if (data_s != cand) begin
                    cnt <= CW'(1);
                    cand <= data_s;
                end else begin
                    cnt <= cnt_inc;
                    state <= (cnt_inc == DB) ? HELD : QUAL;
                end
                HELD: if (!strobe_s) begin
                    state <= (DEBOUNCE_CYCLES == 1) ? IDLE : RELEASE;
                    cnt <= CW'(1);
                end
                RELEASE: if (strobe_s) state <= HELD;
                else begin
                    cnt <= cnt_inc;
                    state <= (cnt_inc >= DB) ? IDLE : RELEASE;
                end
            endcase
        end
    end
    // sticky overflow flag and saturating drop counter for pushes rejected on a full buffer
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i || clr_i) begin
            overflow_o <= 1'b0;
            drop_count_o <= '0;
        end else if (push && full && !pop) begin
            overflow_o <= 1'b1;
            drop_count_o <= (drop_count_o == DROP_SAT) ? drop_count_o : drop_count_o + 8'd1;
        end
    end
    sync_fifo #(.DATA_W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk(wb_clk_i),
        .rst(wb_rst_i),
        .clr(clr_i),
        .push(push),
        .pop(pop),
        .din(data_s),
        .dout(sym_data_o),
        .valid(sym_valid_o),
        .full(full),
        .level(fifo_level_o)
    );
endmodule

// File: tb/tb_symbol_ingress_sampler.sv
// tb_symbol_ingress_sampler: directed tables, corner sequences and a window-rule reference model
module tb_symbol_ingress_sampler;
    localparam int S = 2;
    localparam int D = 4;
    localparam int DEPTH = 4;
    logic wb_clk_i = 0, wb_rst_i = 1, pad_strobe_i = 0, clr_i = 0, sym_ready_i = 0;
    logic [7:0] pad_data_i = 0;
    logic sym_valid_o, overflow_o;
    logic [7:0] sym_data_o, drop_count_o;
    logic [2:0] fifo_level_o;
    int checks = 0, failures = 0;

    always #5 wb_clk_i = ~wb_clk_i;

    symbol_ingress_sampler dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i), .pad_data_i(pad_data_i),
        .pad_strobe_i(pad_strobe_i), .clr_i(clr_i), .sym_valid_o(sym_valid_o),
        .sym_data_o(sym_data_o), .sym_ready_i(sym_ready_i), .overflow_o(overflow_o),
        .drop_count_o(drop_count_o), .fifo_level_o(fifo_level_o)
    );

    typedef struct {
        logic [31:0] pat;
        logic [7:0]  da;
        logic [7:0]  db;
        int          sw;
        int          n;
        logic [7:0]  sym;
        int          lat;
    } vec_t;
    vec_t tbl[8];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge wb_clk_i);
        #1;
    endtask

    task automatic pulse(input logic [7:0] d, input int hi, input int lo);
        pad_data_i = d;
        pad_strobe_i = 1;
        repeat (hi) step();
        pad_strobe_i = 0;
        repeat (lo) step();
    endtask

    task automatic drain_chk(input logic [7:0] first, input int n);
        int gi = 0;
        sym_ready_i = 1;
        for (int k = 0; k < 3 * n + 4; k++) begin
            if (sym_valid_o) begin
                chk("drain_order", {24'b0, sym_data_o}, first + gi);
                gi++;
            end
            step();
        end
        sym_ready_i = 0;
        chk("drain_count", gi, n);
    endtask

    logic       m_pst [S];
    logic [7:0] m_pdt [S];
    logic       w_st[$];
    logic [7:0] w_d[$];
    logic [7:0] mq[$];
    logic [7:0] mlast;
    bit armed, movf;
    int lowrun, mdrop;

    task automatic model_reset();
        for (int k = 0; k < S; k++) begin
            m_pst[k] = 0;
            m_pdt[k] = 0;
        end
        w_st.delete();
        w_d.delete();
        mq.delete();
        armed = 1;
        lowrun = 0;
        mlast = 0;
        movf = 0;
        mdrop = 0;
    endtask

    // A symbol is accepted when the last D synchronized samples are all high with equal data,
    // provided D consecutive low samples have been seen since the previous acceptance.
    task automatic model_edge();
        logic st;
        logic [7:0] d;
        bit pop, push, ok;
        st = m_pst[S-1];
        d = m_pdt[S-1];
        for (int k = S - 1; k > 0; k--) begin
            m_pst[k] = m_pst[k-1];
            m_pdt[k] = m_pdt[k-1];
        end
        m_pst[0] = pad_strobe_i;
        m_pdt[0] = pad_data_i;
        pop = mq.size() > 0 && sym_ready_i;
        w_st.push_back(st);
        w_d.push_back(d);
        if (w_st.size() > D) begin
            void'(w_st.pop_front());
            void'(w_d.pop_front());
        end
        push = 0;
        if (armed) begin
            ok = w_st.size() == D;
            foreach (w_st[k]) if (!w_st[k] || w_d[k] != d) ok = 0;
            if (ok) begin
                push = 1;
                armed = 0;
                lowrun = 0;
            end
        end else begin
            lowrun = st ? 0 : lowrun + 1;
            if (lowrun >= D) armed = 1;
        end
        if (pop) mlast = mq.pop_front();
        if (push) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else begin
                movf = 1;
                if (mdrop < 255) mdrop++;
            end
        end
    endtask

    initial begin
        int first, cnt_t, seg_left, rdy_pct;
        logic [7:0] lastd;
        logic [20:0] expv;
        tbl[0] = '{32'h0000_03FF, 8'h5A, 8'h5A, 0, 1, 8'h5A, 6};
        tbl[1] = '{32'h0000_0007, 8'h77, 8'h77, 0, 0, 8'h00, 0};
        tbl[2] = '{32'h0000_000F, 8'h3C, 8'h3C, 0, 1, 8'h3C, 6};
        tbl[3] = '{32'h0000_FCFF, 8'hA5, 8'hA5, 0, 1, 8'hA5, 6};
        tbl[4] = '{32'h0000_03FF, 8'h11, 8'h22, 2, 1, 8'h22, 8};
        tbl[5] = '{32'h0000_003F, 8'h10, 8'h20, 3, 0, 8'h00, 0};
        tbl[6] = '{32'h0000_00FF, 8'h44, 8'h99, 4, 1, 8'h44, 6};
        tbl[7] = '{32'hFFFF_FFFF, 8'hC3, 8'hC3, 0, 1, 8'hC3, 6};
        repeat (3) step();
        wb_rst_i = 0;
        chk("rst_valid", {31'b0, sym_valid_o}, 0);
        chk("rst_data", {24'b0, sym_data_o}, 0);
        chk("rst_level", {29'b0, fifo_level_o}, 0);
        chk("rst_ovf", {31'b0, overflow_o}, 0);
        chk("rst_drops", {24'b0, drop_count_o}, 0);

        sym_ready_i = 1;
        for (int r = 0; r < 8; r++) begin
            cnt_t = 0;
            first = -1;
            lastd = 0;
            for (int i = 0; i < 44; i++) begin
                pad_strobe_i = (i < 32) ? tbl[r].pat[i] : 1'b0;
                pad_data_i = (i >= tbl[r].sw) ? tbl[r].db : tbl[r].da;
                step();
                if (sym_valid_o) begin
                    if (first < 0) first = i + 1;
                    cnt_t++;
                    lastd = sym_data_o;
                end
            end
            chk($sformatf("tbl%0d_count", r), cnt_t, tbl[r].n);
            chk($sformatf("tbl%0d_level", r), {29'b0, fifo_level_o}, 0);
            if (tbl[r].n > 0) begin
                chk($sformatf("tbl%0d_data", r), {24'b0, lastd}, {24'b0, tbl[r].sym});
                chk($sformatf("tbl%0d_latency", r), first, tbl[r].lat);
            end
        end

        sym_ready_i = 0;
        for (int k = 1; k <= 6; k++) pulse(8'(k), 6, 8);
        chk("ovf_level", {29'b0, fifo_level_o}, 4);
        chk("ovf_valid", {31'b0, sym_valid_o}, 1);
        chk("ovf_head", {24'b0, sym_data_o}, 8'h01);
        chk("ovf_flag", {31'b0, overflow_o}, 1);
        chk("ovf_drops", {24'b0, drop_count_o}, 2);
        drain_chk(8'h01, 4);

        pulse(8'h51, 6, 8);
        pulse(8'h52, 6, 8);
        chk("clr_pre_level", {29'b0, fifo_level_o}, 2);
        pad_data_i = 8'h53;
        pad_strobe_i = 1;
        repeat (4) step();
        clr_i = 1;
        step();
        clr_i = 0;
        pad_strobe_i = 0;
        chk("clr_level", {29'b0, fifo_level_o}, 0);
        chk("clr_valid", {31'b0, sym_valid_o}, 0);
        chk("clr_ovf", {31'b0, overflow_o}, 0);
        chk("clr_drops", {24'b0, drop_count_o}, 0);
        chk("clr_data", {24'b0, sym_data_o}, 0);
        repeat (10) step();
        chk("clr_no_stale", {29'b0, fifo_level_o}, 0);
        pulse(8'h33, 6, 8);
        chk("post_clr_level", {29'b0, fifo_level_o}, 1);
        chk("post_clr_head", {24'b0, sym_data_o}, 8'h33);
        drain_chk(8'h33, 1);

        clr_i = 1;
        step();
        clr_i = 0;
        for (int k = 0; k < 4; k++) pulse(8'h41 + 8'(k), 6, 8);
        chk("full_level", {29'b0, fifo_level_o}, 4);
        pad_data_i = 8'h45;
        pad_strobe_i = 1;
        repeat (5) step();
        sym_ready_i = 1;
        step();
        sym_ready_i = 0;
        chk("pp_level", {29'b0, fifo_level_o}, 4);
        chk("pp_drops", {24'b0, drop_count_o}, 0);
        chk("pp_ovf", {31'b0, overflow_o}, 0);
        chk("pp_head", {24'b0, sym_data_o}, 8'h42);
        pad_strobe_i = 0;
        repeat (8) step();
        drain_chk(8'h42, 4);

        wb_rst_i = 1;
        pad_strobe_i = 0;
        pad_data_i = 0;
        sym_ready_i = 0;
        repeat (2) step();
        wb_rst_i = 0;
        model_reset();
        seg_left = 0;
        rdy_pct = 50;
        for (int c = 0; c < 3000; c++) begin
            if (c % 300 == 0) rdy_pct = $urandom_range(0, 100);
            if (seg_left == 0) begin
                pad_strobe_i = ~pad_strobe_i;
                seg_left = $urandom_range(1, 10);
            end
            seg_left--;
            if ($urandom_range(0, 7) == 0) pad_data_i = 8'($urandom);
            sym_ready_i = $urandom_range(0, 99) < rdy_pct;
            model_edge();
            step();
            expv = {mq.size() > 0, (mq.size() > 0) ? mq[0] : mlast, 3'(mq.size()), movf, 8'(mdrop)};
            chk("rand_state", {11'b0, sym_valid_o, sym_data_o, fifo_level_o, overflow_o, drop_count_o},
                {11'b0, expv});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/symbol_ingress_sampler.md
Name: symbol_ingress_sampler

Overview:
Upstream front end for the distinct-symbol Bloom counter.
- Takes the raw, asynchronous pad symbol bus and strobe and synchronizes them.
- Debounces the strobe and qualifies the data as stable.
- Buffers each accepted symbol in a small FIFO.
- Presents exactly one valid/ready transfer per physical strobe pulse to the counter stage.
- Guarantees the counter sees clean, single-cycle-accepted symbols instead of glitchy pad levels.

Parameters:
DATA_W, 8, symbol width (pad bits io_in[8:1])
SYNC_STAGES, 2, synchronizer flop depth for data and strobe (>=2)
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept or release a strobe (>=1)
FIFO_DEPTH, 4, symbol buffer entries (power of two, >=2)

Ports:
wb_clk_i  input  1  single clock
wb_rst_i  input  1  synchronous, active-high reset
pad_data_i  input  DATA_W  raw asynchronous symbol bus from pads
pad_strobe_i  input  1  raw asynchronous symbol strobe from pad
clr_i  input  1  synchronous clear (already synchronized by the wrapper)
sym_valid_o  output  1  FIFO head valid
sym_data_o  output  DATA_W  FIFO head symbol
sym_ready_i  input  1  downstream accepts head
overflow_o  output  1  sticky: a symbol was dropped on a full FIFO
drop_count_o  output  8  dropped-symbol count, saturating at 255
fifo_level_o  output  $clog2(FIFO_DEPTH)+1  current occupancy

Behaviour:
Reset and clear:
- On wb_rst_i: synchronizers=0, FSM=IDLE, debounce count=0, FIFO empty, sym_valid_o=0, sym_data_o=0, overflow_o=0, drop_count_o=0, fifo_level_o=0.
- clr_i has the same effect as wb_rst_i, minus the synchronizer flush.
- Reset or clear mid-qualification discards the candidate; no push occurs.

Synchronizer:
- strobe_s and data_s are pad inputs delayed SYNC_STAGES cycles.

FSM (count saturates at DEBOUNCE_CYCLES):
- IDLE: strobe_s=1 -> QUAL, count=1, cand=data_s.
- QUAL, strobe_s=0: -> IDLE, no push.
- QUAL, strobe_s=1 and data_s!=cand: stay QUAL, count=1, cand=data_s (restart).
- QUAL, strobe_s=1 and data_s==cand: count+1. When the count reaches DEBOUNCE_CYCLES: push cand, -> HELD.
- DEBOUNCE_CYCLES=1: push occurs directly in the IDLE->QUAL cycle.
- HELD: strobe_s=0 -> RELEASE, count=1.
- RELEASE: strobe_s=1 -> HELD (glitch, no new symbol).
- RELEASE: strobe_s=0 for DEBOUNCE_CYCLES consecutive cycles -> IDLE.
- Exactly one push per accepted pulse. A strobe held high indefinitely yields one symbol.

Latency:
- Pad strobe rise with stable data at cycle p -> sym_valid_o=1 at cycle p+SYNC_STAGES+DEBOUNCE_CYCLES if the FIFO was empty (6 cycles with defaults).

FIFO:
- First-word-fall-through: sym_data_o is the head whenever sym_valid_o=1.
- Pop when sym_valid_o && sym_ready_i.
- sym_data_o holds its last value when empty.
- Push and pop in the same cycle: both take effect, level unchanged.
- Push on full with a simultaneous pop: accepted.
- Push on full without a pop:
  - symbol dropped, overflow_o<=1 (sticky until reset/clear);
  - drop_count_o increments, saturating at 255;
  - FIFO contents are unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- fifo_level_o ranges 0..FIFO_DEPTH.

Handshake:
- sym_valid_o, once high, stays high and sym_data_o stays stable until popped.

Decomposition:
- Package ingress_pkg holds:
  - the FSM state enum (IDLE, QUAL, HELD, RELEASE);
  - default parameter constants;
  - the DROP_SAT=255 constant.
- Sub-module sync_fifo (parameters DATA_W, DEPTH):
  - push/pop, full/empty, level;
  - FWFT head output.
- The top level holds the synchronizers, FSM, debounce counter and overflow/drop logic.

Test Plan:
1. Stable single pulse: pad_data_i=0x5A, pad_strobe_i high 10 cycles, sym_ready_i=1 -> one transfer of 0x5A, valid first seen 6 cycles after strobe rise, level returns to 0.
2. Glitch rejection: strobe high 3 cycles then low -> no push. Strobe high 8 cycles with a 2-cycle low dip after acceptance -> exactly one symbol.
3. Data change during qualify: strobe high, data 0x11 for 2 cycles then 0x22 steady -> single symbol 0x22 pushed, 4 cycles after the change reaches data_s.
4. Overflow: sym_ready_i=0, six clean pulses 0x01..0x06 -> level=4, head 0x01, overflow_o=1, drop_count_o=2. Then ready=1 -> pops 0x01..0x04 in order.
5. Full with simultaneous push/pop: FIFO full, ready=1 in the push cycle -> push accepted, level stays 4, no drop.
6. Clear mid-operation: assert clr_i during QUAL with level=2 -> level=0, sym_valid_o=0, overflow_o=0, no stale push. A subsequent pulse 0x33 is delivered normally.
